regfile_op_sequencer: RTL and testbench
=======================================

// Module: regfile_op_sequencer
// PURPOSE
//   Multi-cycle issue/execute controller for the 16x16 register file (2 async read ports, 1 sync write port).
//   Accepts one instruction per valid/ready handshake and drives the read addresses.
//   Captures both operands, computes an ALU result and writes it back through the write port.
//   Sits directly around the register file: upstream of its address/write inputs, downstream of its read ports.
// PARAMETERS
//   DATA_W  16  operand/result width; must match the register file data width
//   ADDR_W  4   register address width (2**ADDR_W registers)
// PORTS
//   clk            in   1       rising-edge clock
//   rst_n          in   1       asynchronous active-low reset
//   instr_valid    in   1       instruction present on instr_* inputs
//   instr_ready    out  1       high only in IDLE; handshake completes when valid&ready at posedge
//   instr_op       in   4       opcode (table below)
//   instr_rd       in   ADDR_W  destination register
//   instr_rs1      in   ADDR_W  source register 1
//   instr_rs2      in   ADDR_W  source register 2
//   instr_imm      in   8       immediate, used by LDI only
//   rf_read_addr1  out  ADDR_W  to register file read address 1 (= latched rs1)
//   rf_read_addr2  out  ADDR_W  to register file read address 2 (= latched rs2)
//   rf_read_port1  in   DATA_W  from register file read port 1
//   rf_read_port2  in   DATA_W  from register file read port 2
//   rf_write_addr  out  ADDR_W  to register file write address (= latched rd)
//   rf_data_in     out  DATA_W  to register file write data (= result register)
//   rf_write_en    out  1       high for exactly one cycle, in WRITE state only
//   done           out  1       one-cycle pulse in WRITE state, for every instruction including NOP/illegal
//   flag_zero      out  1       result==0 of the last executed writing instruction
//   flag_carry     out  1       ADD carry-out / SUB borrow; cleared by all other writing ops
// BEHAVIOUR
//   - Reset: state=IDLE, instr_ready=1, rf_write_en=0, done=0, flags=0; all latched fields and result=0.
//   - FSM IDLE->READ->EXEC->WRITE->IDLE, one cycle per state; no stalls; throughput 1 instr per 4 cycles.
//   - IDLE: on valid&ready, latch op/rd/rs1/rs2/imm.
//   - READ: addresses are stable from the latched fields; capture rf_read_port1/2 into opA/opB at the end of the cycle.
//   - EXEC: result <= ALU(opA,opB); flags update here.
//   - WRITE: rf_write_en=1 (except for non-writing ops), done=1, then return to IDLE.
//   - Latency: accept at edge N; write committed at edge N+3; instr_ready high again in cycle N+3.
//   - Opcodes: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL1 A, 7 SHR1 A (logical),
//     8 LDI (zero-extended imm), 9 MOV A, 10 MUL (optional), 15 NOP; all others are illegal.
//   - Arithmetic is modulo 2**DATA_W. Carry is bit DATA_W of the (DATA_W+1)-bit sum/difference.
//   - NOP/illegal: no write, flags unchanged, done still pulses.
//   - rd==rs1/rs2 is legal: operands are captured in READ, before the write.
//   - instr_valid while busy is ignored (ready=0); the instruction must be held until accepted.
//   - Reset asserted in any state: immediate return to IDLE; rf_write_en drops asynchronously; no partial write.
// CONFIGURATION
//   REGFILE_SEQ_MUL_EN defined: op 10 = MUL, result = low DATA_W bits of A*B, carry=|high bits.
//   Undefined: op 10 is illegal (no write, done pulses); no multiplier is synthesised.
// STRUCTURE
//   regfile_seq_pkg: opcode localparams, FSM state encoding (2-bit), default widths.
//   Sub-module regfile_seq_alu: combinational, (op,A,B,imm) -> result, carry, writes.
//   The FSM, latches and flags stay in the top module.
// TESTING (bench instantiates this block together with the register file)
//   1. LDI rd=4 imm=0xB8 -> rf_write_en only in cycle N+3 with addr 4 and data 0x00B8; r4 reads 184.
//   2. r4=5560, r12=76860 (stores 11324); ADD rd=3 -> r3=16884, zero=0, carry=0.
//   3. r1=0xFFFF, r2=0x0001; ADD -> result 0x0000, zero=1, carry=1; then AND -> carry cleared.
//   4. r4=5560, r9=7380; SUB rd=5 rs1=4 rs2=9 -> r5=0xF8E4, carry(borrow)=1.
//   5. Back-to-back valid held high: 2nd instruction accepted only at edge N+4. rst_n low during EXEC -> no write, ready=1.
//   6. op 10 with r1=200, r2=300: MUL_EN -> 0xEA60, carry=0; without macro -> no write, done pulses.

Source files
------------

// File: rtl/regfile_seq_pkg.sv
// Shared opcodes, FSM encoding and default widths for the register-file op sequencer.
// REGFILE_SEQ_MUL_EN adds MUL (op 10) to the set of writing opcodes.
package regfile_seq_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;
  localparam int OP_W       = 4;
  localparam int IMM_W      = 8;

  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_AND  = 4'd2;
  localparam logic [OP_W-1:0] OP_OR   = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
  localparam logic [OP_W-1:0] OP_NOT  = 4'd5;
  localparam logic [OP_W-1:0] OP_SHL1 = 4'd6;
  localparam logic [OP_W-1:0] OP_SHR1 = 4'd7;
  localparam logic [OP_W-1:0] OP_LDI  = 4'd8;
  localparam logic [OP_W-1:0] OP_MOV  = 4'd9;
  localparam logic [OP_W-1:0] OP_MUL  = 4'd10;
  localparam logic [OP_W-1:0] OP_NOP  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  // Only writing opcodes touch the register file and the flags.
  function automatic logic op_writes(input logic [OP_W-1:0] op);
    logic w;
    w = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_NOT, OP_SHL1, OP_SHR1, OP_LDI, OP_MOV: w = 1'b1;
`ifdef REGFILE_SEQ_MUL_EN
      OP_MUL: w = 1'b1;
`endif
      default: w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/regfile_op_sequencer_if.sv
// Instruction handshake plus register-file address/data bus of the op sequencer.
// master = instruction source and register file side, slave = sequencer.
interface regfile_op_sequencer_if
  import regfile_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              instr_valid;
  logic              instr_ready;
  logic [OP_W-1:0]   instr_op;
  logic [ADDR_W-1:0] instr_rd;
  logic [ADDR_W-1:0] instr_rs1;
  logic [ADDR_W-1:0] instr_rs2;
  logic [IMM_W-1:0]  instr_imm;
  logic [ADDR_W-1:0] rf_read_addr1;
  logic [ADDR_W-1:0] rf_read_addr2;
  logic [DATA_W-1:0] rf_read_port1;
  logic [DATA_W-1:0] rf_read_port2;
  logic [ADDR_W-1:0] rf_write_addr;
  logic [DATA_W-1:0] rf_data_in;
  logic              rf_write_en;
  logic              done;
  logic              flag_zero;
  logic              flag_carry;

  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
    input  rf_read_port1, rf_read_port2,
    output instr_ready, rf_read_addr1, rf_read_addr2,
    output rf_write_addr, rf_data_in, rf_write_en, done, flag_zero, flag_carry
  );

  modport master (
    output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
    output rf_read_port1, rf_read_port2,
    input  instr_ready, rf_read_addr1, rf_read_addr2,
    input  rf_write_addr, rf_data_in, rf_write_en, done, flag_zero, flag_carry
  );
endinterface

// File: rtl/regfile_seq_alu.sv
// Combinational ALU: (op, A, B, imm) -> result, carry/borrow and write-enable; zero latency.
// REGFILE_SEQ_MUL_EN builds the multiplier for op 10; otherwise op 10 falls through as illegal.
module regfile_seq_alu
  import regfile_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [IMM_W-1:0]  imm,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              writes
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;
`ifdef REGFILE_SEQ_MUL_EN
  logic [2*DATA_W-1:0] prod;
`endif

  // Bit DATA_W of the widened difference is the borrow out.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
`ifdef REGFILE_SEQ_MUL_EN
  assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
`endif

  assign writes = op_writes(op);

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_SUB: begin
        result = diff[DATA_W-1:0];
        carry  = diff[DATA_W];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      OP_SHL1: result = {a[DATA_W-2:0], 1'b0};
      OP_SHR1: result = {1'b0, a[DATA_W-1:1]};
      OP_LDI:  result = {{(DATA_W-IMM_W){1'b0}}, imm};
      OP_MOV:  result = a;
`ifdef REGFILE_SEQ_MUL_EN
      OP_MUL: begin
        result = prod[DATA_W-1:0];
        carry  = |prod[2*DATA_W-1:DATA_W];
      end
`endif
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/regfile_op_sequencer.sv
// Issue/execute controller around a 2R1W register file: IDLE->READ->EXEC->WRITE, write at accept+3 edges.
// Ready only in IDLE, so one instruction per 4 cycles; REGFILE_SEQ_MUL_EN enables the MUL opcode.
module regfile_op_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  regfile_op_sequencer_if.slave   bus
);

  state_t            state_q, state_d;
  logic [OP_W-1:0]   op_q;
  logic [ADDR_W-1:0] rd_q, rs1_q, rs2_q;
  logic [IMM_W-1:0]  imm_q;
  logic [DATA_W-1:0] opa_q, opb_q, result_q;
  logic              writes_q;
  logic              flag_zero_q, flag_carry_q;

  logic              ready;
  logic              write_en;
  logic              done;
  logic              accept;

  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_writes;

  regfile_seq_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op_q),
    .a      (opa_q),
    .b      (opb_q),
    .imm    (imm_q),
    .result (alu_result),
    .carry  (alu_carry),
    .writes (alu_writes)
  );

  assign accept = bus.instr_valid && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Write enable is decoded from the state register so reset drops it immediately.
  always_comb begin
    state_d  = state_q;
    ready    = 1'b0;
    write_en = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (bus.instr_valid) state_d = ST_READ;
      end
      ST_READ:  state_d = ST_EXEC;
      ST_EXEC:  state_d = ST_WRITE;
      ST_WRITE: begin
        write_en = writes_q;
        done     = 1'b1;
        state_d  = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= '0;
      rd_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      imm_q        <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      result_q     <= '0;
      writes_q     <= 1'b0;
      flag_zero_q  <= 1'b0;
      flag_carry_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= bus.instr_op;
        rd_q  <= bus.instr_rd;
        rs1_q <= bus.instr_rs1;
        rs2_q <= bus.instr_rs2;
        imm_q <= bus.instr_imm;
      end
      // Operands are sampled before the write, so rd may alias rs1/rs2.
      if (state_q == ST_READ) begin
        opa_q <= bus.rf_read_port1;
        opb_q <= bus.rf_read_port2;
      end
      if (state_q == ST_EXEC) begin
        writes_q <= alu_writes;
        if (alu_writes) begin
          result_q     <= alu_result;
          flag_zero_q  <= (alu_result == '0);
          flag_carry_q <= alu_carry;
        end
      end
    end
  end

  assign bus.instr_ready   = ready;
  assign bus.rf_read_addr1 = rs1_q;
  assign bus.rf_read_addr2 = rs2_q;
  assign bus.rf_write_addr = rd_q;
  assign bus.rf_data_in    = result_q;
  assign bus.rf_write_en   = write_en;
  assign bus.done          = done;
  assign bus.flag_zero     = flag_zero_q;
  assign bus.flag_carry    = flag_carry_q;

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Directed bench: sequencer plus a behavioural 16x16 register file (async read, sync write).
module tb_regfile_op_sequencer;
  import regfile_seq_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  regfile_op_sequencer_if #(.DATA_W(16), .ADDR_W(4)) bus ();

  regfile_op_sequencer #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [15:0] rf [16];
  logic        pre_we;
  logic [3:0]  pre_addr;
  logic [15:0] pre_dat;

  assign bus.rf_read_port1 = rf[bus.rf_read_addr1];
  assign bus.rf_read_port2 = rf[bus.rf_read_addr2];

  always @(posedge clk) begin
    if (bus.rf_write_en) rf[bus.rf_write_addr] <= bus.rf_data_in;
    else if (pre_we)     rf[pre_addr] <= pre_dat;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [3:0] a, input logic [15:0] d);
    pre_we = 1'b1; pre_addr = a; pre_dat = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  int          we_cnt, done_cnt;
  logic [3:0]  w_addr;
  logic [15:0] w_data;
  int          we_cycle;

  // Issue one instruction from a negedge; returns at the negedge of the cycle after WRITE.
  task automatic run(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                     input logic [3:0] rs2, input logic [7:0] imm);
    int w;
    w = 0;
    while (!bus.instr_ready && w < 8) begin
      @(negedge clk);
      w++;
    end
    if (!bus.instr_ready) chk("ready_timeout", 32'(bus.instr_ready), 32'd1);
    bus.instr_valid = 1'b1;
    bus.instr_op = op; bus.instr_rd = rd; bus.instr_rs1 = rs1; bus.instr_rs2 = rs2;
    bus.instr_imm = imm;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    we_cnt = 0; done_cnt = 0; w_addr = '0; w_data = '0; we_cycle = -1;
    for (int c = 0; c < 4; c++) begin
      if (bus.rf_write_en) begin
        we_cnt++; w_addr = bus.rf_write_addr; w_data = bus.rf_data_in; we_cycle = c;
      end
      if (bus.done) done_cnt++;
      if (c < 3) @(negedge clk);
    end
  endtask

  int rdy_low;

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_dat = '0;
    bus.instr_valid = 1'b0; bus.instr_op = '0; bus.instr_rd = '0;
    bus.instr_rs1 = '0; bus.instr_rs2 = '0; bus.instr_imm = '0;
    for (int i = 0; i < 16; i++) rf[i] = 16'h0;
    #12;
    chk("rst_ready", 32'(bus.instr_ready), 32'd1);
    chk("rst_we", 32'(bus.rf_write_en), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_flags", {30'd0, bus.flag_zero, bus.flag_carry}, 32'd0);
    chk("rst_data", 32'(bus.rf_data_in), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // LDI: single write in the WRITE cycle (third cycle after accept)
    run(OP_LDI, 4'd4, 4'd0, 4'd0, 8'hB8);
    chk("ldi_we_cnt", 32'(we_cnt), 32'd1);
    chk("ldi_we_cycle", 32'(we_cycle), 32'd2);
    chk("ldi_addr", 32'(w_addr), 32'd4);
    chk("ldi_data", 32'(w_data), 32'h00B8);
    chk("ldi_done_cnt", 32'(done_cnt), 32'd1);
    chk("ldi_r4", 32'(rf[4]), 32'd184);
    chk("ldi_ready", 32'(bus.instr_ready), 32'd1);

    // ADD without carry; 76860 is stored modulo 2^16 as 11324
    preload(4'd4, 16'd5560);
    preload(4'd12, 16'(76860));
    run(OP_ADD, 4'd3, 4'd4, 4'd12, 8'h00);
    chk("add_r3", 32'(rf[3]), 32'd16884);
    chk("add_flags", {30'd0, bus.flag_zero, bus.flag_carry}, 32'b00);

    // ADD wrapping to zero, then AND clears carry
    preload(4'd1, 16'hFFFF);
    preload(4'd2, 16'h0001);
    run(OP_ADD, 4'd6, 4'd1, 4'd2, 8'h00);
    chk("addc_r6", 32'(rf[6]), 32'h0000);
    chk("addc_flags", {30'd0, bus.flag_zero, bus.flag_carry}, 32'b11);
    run(OP_AND, 4'd7, 4'd1, 4'd2, 8'h00);
    chk("and_r7", 32'(rf[7]), 32'h0001);
    chk("and_flags", {30'd0, bus.flag_zero, bus.flag_carry}, 32'b00);

    // SUB with borrow
    preload(4'd9, 16'd7380);
    run(OP_SUB, 4'd5, 4'd4, 4'd9, 8'h00);
    chk("sub_r5", 32'(rf[5]), 32'hF8E4);
    chk("sub_flags", {30'd0, bus.flag_zero, bus.flag_carry}, 32'b01);

    // NOP and illegal: no write, flags held, done still pulses
    run(OP_NOP, 4'd5, 4'd1, 4'd1, 8'h00);
    chk("nop_we_cnt", 32'(we_cnt), 32'd0);
    chk("nop_done_cnt", 32'(done_cnt), 32'd1);
    chk("nop_flags", {30'd0, bus.flag_zero, bus.flag_carry}, 32'b01);
    run(4'd12, 4'd5, 4'd1, 4'd1, 8'h00);
    chk("ill_we_cnt", 32'(we_cnt), 32'd0);
    chk("ill_done_cnt", 32'(done_cnt), 32'd1);
    chk("ill_r5", 32'(rf[5]), 32'hF8E4);

    // Remaining unary/logical ops, including rd aliasing rs1
    run(OP_SHL1, 4'd8, 4'd9, 4'd0, 8'h00);
    chk("shl_r8", 32'(rf[8]), 32'd14760);
    run(OP_SHR1, 4'd8, 4'd1, 4'd0, 8'h00);
    chk("shr_r8", 32'(rf[8]), 32'h7FFF);
    run(OP_NOT, 4'd10, 4'd2, 4'd0, 8'h00);
    chk("not_r10", 32'(rf[10]), 32'hFFFE);
    run(OP_OR, 4'd10, 4'd4, 4'd2, 8'h00);
    chk("or_r10", 32'(rf[10]), 32'd5561);
    run(OP_MOV, 4'd11, 4'd9, 4'd0, 8'h00);
    chk("mov_r11", 32'(rf[11]), 32'd7380);
    run(OP_XOR, 4'd1, 4'd1, 4'd1, 8'h00);
    chk("xor_r1", 32'(rf[1]), 32'h0000);
    chk("xor_zero", 32'(bus.flag_zero), 32'd1);

    // Back-to-back: valid held high, second instruction waits for IDLE
    bus.instr_valid = 1'b1;
    bus.instr_op = OP_LDI; bus.instr_rd = 4'd14; bus.instr_imm = 8'h11;
    @(negedge clk);
    bus.instr_rd = 4'd15; bus.instr_imm = 8'h22;
    rdy_low = 0;
    while (!bus.instr_ready && rdy_low < 10) begin
      rdy_low++;
      @(negedge clk);
    end
    chk("b2b_busy_cycles", 32'(rdy_low), 32'd3);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    chk("b2b_ready_low", 32'(bus.instr_ready), 32'd0);
    chk("b2b_r14", 32'(rf[14]), 32'h0011);
    repeat (3) @(negedge clk);
    chk("b2b_r15", 32'(rf[15]), 32'h0022);

    // Reset during EXEC: no write, back to IDLE
    preload(4'd11, 16'h1234);
    bus.instr_valid = 1'b1;
    bus.instr_op = OP_SUB; bus.instr_rd = 4'd11; bus.instr_rs1 = 4'd4; bus.instr_rs2 = 4'd9;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_exec_we", 32'(bus.rf_write_en), 32'd0);
    chk("rst_exec_ready", 32'(bus.instr_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_exec_r11", 32'(rf[11]), 32'h1234);
    chk("rst_exec_done", 32'(bus.done), 32'd0);

    // Opcode 10: MUL when enabled, illegal otherwise
    preload(4'd1, 16'd200);
    preload(4'd2, 16'd300);
    preload(4'd13, 16'h5555);
    run(OP_MUL, 4'd13, 4'd1, 4'd2, 8'h00);
    chk("mul_done_cnt", 32'(done_cnt), 32'd1);
`ifdef REGFILE_SEQ_MUL_EN
    chk("mul_we_cnt", 32'(we_cnt), 32'd1);
    chk("mul_r13", 32'(rf[13]), 32'hEA60);
    chk("mul_carry", 32'(bus.flag_carry), 32'd0);
`else
    chk("mul_we_cnt", 32'(we_cnt), 32'd0);
    chk("mul_r13", 32'(rf[13]), 32'h5555);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
